keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
- Upstream input stage for the stopwatch/calculator top level. Scans a 4x4 active-low matrix keypad, debounces it and produces a key code.
- Outputs: a held-level valid and a single-cycle press pulse. Consumers are the stopwatch control (codes 10–13) and the calculator operand reader (digits 0–9).
- Replaces raw, bouncy key reporting with exactly one event per physical press.

Parameters:
- SCAN_DIV, 50000: clock cycles each row is driven (dwell); min 4.
- DEBOUNCE_SCANS, 20: consecutive full scans a change must persist before it is accepted; min 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- line  out  4  row drive, active-low, exactly one bit low at all times
- column  in  4  column sense, active-low (0 = key closed on the driven row), asynchronous
- key_code  out  4  code of the accepted key; holds its last value after release
- key_valid  out  1  high while the accepted key is held (debounced)
- key_pulse  out  1  one-cycle strobe on each accepted press

Behaviour:
- Key map (row,col to code). Row r is driven by line[r]; column c is sensed on column[c].
  - row0: 1 2 3 A (10)
  - row1: 4 5 6 B (11)
  - row2: 7 8 9 C (12)
  - row3: * (14) 0 # (15) D (13)
- Synchronizer: column passes through 2 flops before use.
- Scan:
  - Row index 0..3 and a dwell counter 0..SCAN_DIV-1. line = ~(1<<row).
  - The synchronized column is sampled on the last dwell cycle of each row, then the row advances. Row 3 wraps to 0.
  - A full scan is 4*SCAN_DIV cycles. The scan-end cycle is the row-3 sample cycle.
- Raw key per scan: among closed keys, the lowest index r*4+c wins. No key closed = NONE. The result is evaluated at scan end.
- FSM, evaluated only at scan end; cnt saturates at DEBOUNCE_SCANS:
  - IDLE:
    - raw = NONE: stay.
    - raw = k: cand <= k, cnt <= 1, go to DB_PRESS. If DEBOUNCE_SCANS = 1, go directly to PRESSED.
  - DB_PRESS:
    - raw = cand: cnt++.
    - raw = NONE: go to IDLE.
    - raw = other key j: cand <= j, cnt <= 1.
    - On cnt reaching DEBOUNCE_SCANS: go to PRESSED, key_code <= cand, key_valid <= 1, key_pulse <= 1.
  - PRESSED:
    - raw = cand: stay.
    - Otherwise (NONE or a different key): cnt <= 1, go to DB_RELEASE.
  - DB_RELEASE:
    - raw = cand: back to PRESSED, no pulse.
    - Otherwise: cnt++. On reaching DEBOUNCE_SCANS: go to IDLE, key_valid <= 0.
- Outputs are registered and visible the cycle after scan end.
- key_pulse is high for exactly 1 cycle per accepted press.
- Sliding from key X to key Y without a gap:
  - Counts as a release of X (DEBOUNCE_SCANS scans).
  - Then IDLE sees Y and runs a full press debounce.
  - Result: one pulse per key, with no intervening pulse while X is still held.
- Reset:
  - line = 4'b1110, row = 0, dwell = 0, state IDLE, cnt = 0.
  - key_code = 0, key_valid = 0, key_pulse = 0, synchronizer flops = 4'hF.
  - Reset mid-debounce or mid-press discards all progress; no pulse is emitted as a result of reset.
- Press latency from a steady closure aligned to scan start: DEBOUNCE_SCANS full scans plus 1 cycle, plus up to one extra scan if the closure misses the sample point.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 16 cycles). The matrix model drives column[c]=0 iff line[r]=0 and key(r,c) is closed.
1. Reset: rst=1 for 2 cycles, no keys -> line=1110, key_valid=0, key_pulse=0, key_code=0. line then steps 1110, 1101, 1011, 0111 every 4 cycles and wraps; no pulse for 200 cycles.
2. Press '5' (r1,c1) steady for 15 scans, then release -> single key_pulse with key_code=5 and key_valid=1 within 3–4 scans. No further pulse while held. key_valid=0 3–4 scans after release; key_code stays 5.
3. Bounce: 'B' (r1,c3) toggled closed/open every alternate scan for 8 scans -> no pulse, key_valid=0. Then held steady -> one pulse, key_code=11.
4. '1' (r0,c0) and 'D' (r3,c3) closed together -> key_code=1, one pulse. Release '1' only -> release debounce, then a new press of 13 with one pulse.
5. Hold 'A' (code 10), then slide to 'C' (r2,c3) with no gap -> pulse with 10. key_valid falls after 3 scans. Then a pulse with 12 after 3 more scans; exactly 2 pulses total.
6. Press '7' and assert rst for 1 cycle after 2 scans -> no pulse; outputs at reset values. Keep '7' held -> pulse with key_code=7 only after 3 full post-reset scans.

Source files
------------

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix and key-event bundle for keypad_scan_debounce.
// Signals:
//   line      row drive to the matrix, active-low, one row low at a time
//   column    column sense from the matrix, active-low, asynchronous
//   key_code  code of the most recently accepted key
//   key_valid high while the accepted key remains held
//   key_pulse one-cycle strobe per accepted press
// master: the scanner side; slave: the matrix/consumer side.
interface keypad_scan_debounce_if;
    logic [3:0] line;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pulse;

    modport master (
        output line,
        output key_code,
        output key_valid,
        output key_pulse,
        input  column
    );

    modport slave (
        input  line,
        input  key_code,
        input  key_valid,
        input  key_pulse,
        output column
    );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 active-low keypad scanner with scan-rate debounce and key events.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   kp   keypad_scan_debounce_if.master (line/column matrix, key outputs)
// Parameters:
//   SCAN_DIV       cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS full scans a change must persist (>= 1)
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input logic                    clk,
    input logic                    rst,
    keypad_scan_debounce_if.master kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_t;

    // Matrix index (row*4 + col) to key code.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        unique case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [1:0]    row_q;
    logic [DW-1:0] dwell_q;
    logic          hit_q;
    logic [3:0]    idx_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          pulse_q, pulse_d;

    logic          sample;
    logic          scan_end;
    logic [3:0]    col_n;
    logic          row_hit;
    logic [1:0]    col_sel;
    logic [3:0]    cur_idx;
    logic          keep_prev;
    logic          scan_hit;
    logic [3:0]    scan_idx;
    logic          same;
    logic [CW-1:0] cnt_inc;

    assign sample   = (dwell_q == DWELL_LAST);
    assign scan_end = sample && (row_q == 2'd3);
    assign col_n    = ~sync2_q;
    assign row_hit  = |col_n;

    // Lowest closed column on the driven row wins.
    always_comb begin
        col_sel = 2'd3;
        if (col_n[0]) begin
            col_sel = 2'd0;
        end else if (col_n[1]) begin
            col_sel = 2'd1;
        end else if (col_n[2]) begin
            col_sel = 2'd2;
        end
    end

    assign cur_idx = {row_q, col_sel};

    // A hit from an earlier row of this scan has a lower index and
    // takes priority; row 0 starts a fresh scan.
    assign keep_prev = hit_q && (row_q != 2'd0);
    assign scan_hit  = row_hit || keep_prev;
    assign scan_idx  = keep_prev ? idx_q : cur_idx;

    assign same    = scan_hit && (scan_idx == cand_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            row_q   <= 2'd0;
            dwell_q <= '0;
            hit_q   <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            sync1_q <= kp.column;
            sync2_q <= sync1_q;
            if (sample) begin
                dwell_q <= '0;
                row_q   <= row_q + 2'd1;
                hit_q   <= scan_hit;
                idx_q   <= scan_idx;
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_hit) begin
                        cand_d = scan_idx;
                        cnt_d  = CNT_ONE;
                        if (CNT_MAX == CNT_ONE) begin
                            state_d = PRESSED;
                            code_d  = key_map(scan_idx);
                            valid_d = 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = DB_PRESS;
                        end
                    end
                end
                DB_PRESS: begin
                    if (!scan_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (same) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = PRESSED;
                            code_d  = key_map(cand_q);
                            valid_d = 1'b1;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        cand_d = scan_idx;
                        cnt_d  = CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!same) begin
                        cnt_d = CNT_ONE;
                        if (CNT_MAX == CNT_ONE) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end else begin
                            state_d = DB_RELEASE;
                        end
                    end
                end
                DB_RELEASE: begin
                    if (same) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign kp.line      = ~(4'b0001 << row_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a 4x4 matrix model.
// SCAN_DIV=4, DEBOUNCE_SCANS=3: one scan is 16 cycles.
module tb_keypad_scan_debounce;

    logic        clk;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  col_m;
    int          total;
    int          bad;
    int          cyc;
    int          npulse;
    int          dbl;
    int          pulse_cyc;
    logic        prev_pulse;
    int          t0;
    int          n0;

    keypad_scan_debounce_if kp();

    keypad_scan_debounce #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_m = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!kp.line[r] && keys[r*4+c]) begin
                    col_m[c] = 1'b0;
                end
            end
        end
    end

    assign kp.column = col_m;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kp.key_pulse === 1'b1) begin
            npulse    <= npulse + 1;
            pulse_cyc <= cyc;
            if (prev_pulse) dbl <= dbl + 1;
        end
        prev_pulse <= (kp.key_pulse === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cw(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return at the negedge where row 0 dwell 0 of a new scan is visible.
    task automatic sync_scan();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = kp.line;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && kp.line == 4'b1110) found = 1'b1;
            prev = kp.line;
        end
        if (!found) chk("scan_sync_timeout", 0, 1);
    endtask

    initial begin
        logic [3:0] e;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        npulse     = 0;
        dbl        = 0;
        pulse_cyc  = 0;
        prev_pulse = 1'b0;
        keys       = 16'h0;
        rst        = 1'b1;

        // 1: reset and scan sequence
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_line", kp.line, 4'b1110);
        chk("rst_valid", kp.key_valid, 0);
        chk("rst_pulse", kp.key_pulse, 0);
        chk("rst_code", kp.key_code, 0);
        for (int k = 0; k < 20; k++) begin
            e = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_line", kp.line, e);
            @(negedge clk);
        end
        cw(200);
        chk("idle_no_pulse", npulse, 0);

        // 2: press '5'
        sync_scan();
        keys[5] = 1'b1;
        t0 = cyc;
        n0 = npulse;
        cw(40);
        chk("t2_early_valid", kp.key_valid, 0);
        chk("t2_early_pulse", npulse, n0);
        cw(12);
        chk("t2_pulse", npulse, n0 + 1);
        chk("t2_code", kp.key_code, 5);
        chk("t2_valid", kp.key_valid, 1);
        chk("t2_latency", pulse_cyc - t0, 48);
        cw(188);
        chk("t2_held_one_pulse", npulse, n0 + 1);
        sync_scan();
        keys = 16'h0;
        cw(40);
        chk("t2_rel_early", kp.key_valid, 1);
        cw(12);
        chk("t2_rel_valid", kp.key_valid, 0);
        chk("t2_rel_code", kp.key_code, 5);

        // 3: bouncing 'B'
        sync_scan();
        n0 = npulse;
        for (int i = 0; i < 8; i++) begin
            keys[7] = (i % 2 == 0);
            cw(16);
        end
        chk("t3_bounce_pulse", npulse, n0);
        chk("t3_bounce_valid", kp.key_valid, 0);
        keys[7] = 1'b1;
        cw(52);
        chk("t3_pulse", npulse, n0 + 1);
        chk("t3_code", kp.key_code, 11);
        keys = 16'h0;
        cw(80);

        // 4: '1' and 'D' together, then release '1'
        sync_scan();
        n0 = npulse;
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        cw(52);
        chk("t4_pulse1", npulse, n0 + 1);
        chk("t4_code1", kp.key_code, 1);
        sync_scan();
        keys[0] = 1'b0;
        cw(52);
        chk("t4_rel_valid", kp.key_valid, 0);
        chk("t4_rel_nopulse", npulse, n0 + 1);
        cw(48);
        chk("t4_pulse2", npulse, n0 + 2);
        chk("t4_code2", kp.key_code, 13);
        chk("t4_valid2", kp.key_valid, 1);
        keys = 16'h0;
        cw(80);

        // 5: slide from 'A' to 'C'
        sync_scan();
        n0 = npulse;
        keys[3] = 1'b1;
        cw(52);
        chk("t5_pulseA", npulse, n0 + 1);
        chk("t5_codeA", kp.key_code, 10);
        sync_scan();
        keys[3]  = 1'b0;
        keys[11] = 1'b1;
        cw(40);
        chk("t5_slide_valid", kp.key_valid, 1);
        cw(12);
        chk("t5_fall_valid", kp.key_valid, 0);
        chk("t5_fall_nopulse", npulse, n0 + 1);
        cw(48);
        chk("t5_pulses", npulse, n0 + 2);
        chk("t5_codeC", kp.key_code, 12);
        keys = 16'h0;
        cw(80);

        // 6: reset during press debounce of '7'
        sync_scan();
        n0 = npulse;
        keys[8] = 1'b1;
        cw(32);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_line", kp.line, 4'b1110);
        chk("t6_rst_valid", kp.key_valid, 0);
        chk("t6_rst_pulse", kp.key_pulse, 0);
        chk("t6_rst_code", kp.key_code, 0);
        cw(44);
        chk("t6_no_early", npulse, n0);
        cw(8);
        chk("t6_pulse", npulse, n0 + 1);
        chk("t6_code", kp.key_code, 7);
        keys = 16'h0;
        cw(20);

        chk("single_cycle_pulse", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
